gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
Self-checking harness block that drives a 2-input combinational gate under test and checks its output against an expected truth table.
- Steps the DUT inputs through all four vectors.
- Waits a programmable settle time per vector, then samples and compares the DUT output.
- Reports pass/fail, an error count and a per-vector failure map.
- Counterpart to the stimulus-only gate benches: this block is the response-checking end.
- Synthesizable, so it can run in hardware as well as simulation.

Parameters:
- TRUTH_TABLE, 4'b1000, expected output per vector; bit i is the expected output for {a,b}=i (default is AND).
- SETTLE_CYCLES, 2, idle cycles each vector is held before sampling; legal range 0..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin a check run; honoured only in IDLE.
- a  output  1  DUT input a (registered).
- b  output  1  DUT input b (registered).
- out_in  input  1  DUT output being checked.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at the end of a run.
- pass  output  1  high when the last completed run had zero mismatches; held until the next start.
- err_count  output  3  number of mismatching vectors in the current/last run (0..4).
- fail_vec  output  4  bit i set if vector i mismatched.

Behaviour:
- Reset values (rst high at an edge): state IDLE; a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; vector index=0; settle counter=0.
- FSM states: IDLE, HOLD, FINISH.
- IDLE: a=b=0.
  - On start=1 at edge E0: go to HOLD; index=0; busy=1; err_count, fail_vec and pass cleared; {a,b}=2'b00 from the cycle after E0.
- HOLD: each vector is held for SETTLE_CYCLES+1 cycles. out_in is sampled on the last edge of the window.
  - Expected value is TRUTH_TABLE[index].
  - Mismatch when out_in !== expected; X or Z on out_in counts as a mismatch.
  - On mismatch: fail_vec[index] set and err_count incremented.
  - Same sampling edge: if index<3, increment index and drive {a,b}=index+1 with the settle counter reset. If index==3, go to FINISH.
- Vector order: {a,b} = 00, 01, 10, 11, with a = index[1] and b = index[0].
- Sample of vector 3 occurs at edge E0+4*(SETTLE_CYCLES+1).
- FINISH (one cycle): done=1; pass=(err_count==0), where err_count includes the vector-3 result; busy=0; a=b=0. Then return to IDLE unconditionally.
- done is high exactly in the cycle following edge E0+4*(SETTLE_CYCLES+1); with the default this is 12 edges after the start edge.
- start while busy (HOLD or FINISH) is ignored; it is neither queued nor able to restart the run.
- start high continuously: a new run begins on the first IDLE edge after FINISH.
- err_count, fail_vec and pass remain stable after done until the next accepted start.
- Reset mid-run: every output returns to its reset value on that edge; no done pulse is produced.
- Settle counter width is max(1, $clog2(SETTLE_CYCLES+1)). With SETTLE_CYCLES=0, each vector lasts one cycle and is sampled on the edge after it is applied.
- err_count saturates by construction at 4; no wrap is possible.

Decomposition:
- Package gate_check_pkg holds:
  - state enum (IDLE, HOLD, FINISH);
  - NUM_VECTORS=4;
  - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.
- One natural sub-module: settle_timer. It is a down-counter loaded with SETTLE_CYCLES and outputs an "expire" strobe marking the sampling edge. Everything else stays in gate_response_checker.

Test Plan:
- Default params, correct AND gate on a/b/out_in, start pulsed one cycle → {a,b} sequence 00,01,10,11, each held 3 cycles; done pulse 12 edges after start; pass=1, err_count=0, fail_vec=4'b0000.
- TRUTH_TABLE=TT_AND but DUT is an OR gate → fail_vec=4'b0110, err_count=2, pass=0; done still at edge 12.
- Reset asserted at edge 5 of a run → the next cycle shows busy=0, a=b=0, err_count=0, fail_vec=0, and done never pulses; a fresh start then completes normally with pass=1.
- start re-pulsed at edges 3 and 7 of a run → ignored; done still at edge 12, results unchanged.
- SETTLE_CYCLES=0, XOR DUT with TRUTH_TABLE=TT_XOR → each vector lasts one cycle; done 4 edges after start; pass=1.
- Second run after a failing run, with the DUT now correct → start clears fail_vec and pass on acceptance; final pass=1, fail_vec=4'b0000.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate response checker.
// No logic, no latency, no flow control.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Bit i is the gate output for {a,b} == i.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_response_checker_settle_timer.sv
// Per-vector settle timer: expire marks the sampling edge, SETTLE_CYCLES+1 cycles after load.
// Reloads itself on expire; no backpressure.
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES);

    logic [CW-1:0] count;

    assign expire = en && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load || expire) begin
            count <= RELOAD;
        end else if (en) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/gate_response_checker.sv
// Steps a 2-input gate through all four vectors and checks each against TRUTH_TABLE; done 4*(SETTLE_CYCLES+1) edges after start.
// start is honoured only in IDLE; a start seen while busy is dropped, never queued.
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE   = TT_AND,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       out_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] LAST_INDEX = 2'(NUM_VECTORS - 1);

    state_t     state;
    logic [1:0] index;
    logic [1:0] index_inc;
    logic       start_acc;
    logic       expire;
    logic       exp_bit;
    logic       mismatch;
    logic [2:0] err_next;
    logic [3:0] fv_next;

    assign start_acc = (state == IDLE) && start;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (start_acc),
        .en    (state == HOLD),
        .expire(expire)
    );

    // Case inequality so an X or Z from the gate is scored as a mismatch.
    always_comb begin
        index_inc       = index + 2'd1;
        exp_bit         = TRUTH_TABLE[index];
        mismatch        = (out_in !== exp_bit);
        err_next        = err_count + {2'b00, mismatch};
        fv_next         = fail_vec;
        fv_next[index]  = fail_vec[index] | mismatch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            index     <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                    if (start) begin
                        state     <= HOLD;
                        index     <= 2'd0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        err_count <= 3'd0;
                        fail_vec  <= 4'd0;
                    end
                end
                HOLD: begin
                    if (expire) begin
                        err_count <= err_next;
                        fail_vec  <= fv_next;
                        if (index == LAST_INDEX) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            pass  <= (err_next == 3'd0);
                            busy  <= 1'b0;
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            index <= index_inc;
                            a     <= index_inc[1];
                            b     <= index_inc[0];
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench: expected run results queued at start, compared at done.
module tb_gate_response_checker;
    import gate_check_pkg::*;

    typedef struct {
        logic       pass;
        logic [2:0] err;
        logic [3:0] fv;
        int         latency;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       a, b, out_in;
    logic       busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;
    logic [3:0] gate_tt;

    logic       start0;
    logic       a0, b0, out0;
    logic       busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fv0;

    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    // Gate under test modelled from a selectable truth table.
    assign out_in = gate_tt[{a, b}];
    assign out0   = a0 ^ b0;

    gate_response_checker #(
        .TRUTH_TABLE  (TT_AND),
        .SETTLE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .out_in   (out_in),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_vec (fail_vec)
    );

    gate_response_checker #(
        .TRUTH_TABLE  (TT_XOR),
        .SETTLE_CYCLES(0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .start    (start0),
        .a        (a0),
        .b        (b0),
        .out_in   (out0),
        .busy     (busy0),
        .done     (done0),
        .pass     (pass0),
        .err_count(err0),
        .fail_vec (fv0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [3:0] mism, input int lat);
        exp_t e;
        e.pass    = (mism == 4'd0);
        e.err     = 3'($countones(mism));
        e.fv      = mism;
        e.latency = lat;
        sb_q.push_back(e);
    endtask

    // One run on the default DUT; gate is the real gate's truth table.
    task automatic run_main(input logic [3:0] gate, input bit repulse, input bit do_rst);
        exp_t e;
        bit   seen;
        gate_tt = gate;
        if (!do_rst) push_exp(gate ^ TT_AND, 12);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("clr_fail_vec", 32'(fail_vec), 32'd0);
        chk("clr_err_count", 32'(err_count), 32'd0);
        chk("clr_pass", 32'(pass), 32'd0);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            start = repulse && (k == 3 || k == 7);
            rst   = do_rst && (k == 5);
            @(posedge clk); #1;
            if (do_rst && k == 5) begin
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_ab", 32'({a, b}), 32'd0);
                chk("rst_err", 32'(err_count), 32'd0);
                chk("rst_fv", 32'(fail_vec), 32'd0);
            end
            if (!do_rst && k < 12 && (k % 3) == 1) begin
                chk("vector_ab", 32'({a, b}), 32'(k / 3));
                chk("busy_hold", 32'(busy), 32'd1);
            end
            if (done) begin
                seen = 1'b1;
                if (!do_rst) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_edge", 32'(k), 32'(e.latency));
                        chk("pass", 32'(pass), 32'(e.pass));
                        chk("err_count", 32'(err_count), 32'(e.err));
                        chk("fail_vec", 32'(fail_vec), 32'(e.fv));
                        chk("busy_done", 32'(busy), 32'd0);
                        chk("ab_done", 32'({a, b}), 32'd0);
                    end
                end
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (do_rst) begin
            chk("no_done_after_rst", 32'(seen), 32'd0);
        end else if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk); #1;
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("hold_pass", 32'(pass), 32'(e.pass));
            chk("hold_fv", 32'(fail_vec), 32'(e.fv));
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        bit   seen;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        start0   = 1'b0;
        gate_tt  = TT_AND;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pass", 32'(pass), 32'd0);
        chk("reset_err", 32'(err_count), 32'd0);
        chk("reset_fv", 32'(fail_vec), 32'd0);
        chk("reset_ab", 32'({a, b}), 32'd0);
        chk("reset_busy0", 32'(busy0), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_main(TT_AND, 1'b0, 1'b0);
        run_main(TT_OR, 1'b0, 1'b0);
        run_main(TT_AND, 1'b0, 1'b0);
        run_main(TT_NAND, 1'b0, 1'b1);
        run_main(TT_AND, 1'b0, 1'b0);
        run_main(TT_XOR, 1'b1, 1'b0);
        run_main(TT_AND, 1'b0, 1'b0);

        // Zero-settle XOR checker: one cycle per vector.
        push_exp(4'd0, 4);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (k < 4) chk("vector_ab0", 32'({a0, b0}), 32'(k));
            if (done0) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow0", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("done_edge0", 32'(k), 32'(e.latency));
                    chk("pass0", 32'(pass0), 32'(e.pass));
                    chk("err0", 32'(err0), 32'(e.err));
                    chk("fv0", 32'(fv0), 32'(e.fv));
                end
            end
        end
        if (!seen) chk("done0_timeout", 32'd0, 32'd1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
